proc_input_memory: RTL and testbench

Paged input memory that serves one input port of `processingmodule`. It is written by the upstream stage one entry per cycle, counts entries per event, and reports that count on `number_out` for the `number_in_x_y` input. It returns stored data at `data_out` one cycle after the processing module drives `read_add_x_y`. Four event pages rotate on `start[0]`, so upstream can fill the current event while the processing module reads earlier ones.

---
 rtl/proc_input_memory.sv | 82 ++++++++
 tb/tb_proc_input_memory.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/proc_input_memory.sv
// Four-page rotating input memory: upstream fills the current event page while
// the consumer reads earlier pages; each page keeps its own entry count.
module proc_input_memory #(
   parameter int WIDTH    = 36,
   parameter int MEM_SIZE = 6
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [1:0]            i_start,
   input  logic                  i_input_valid,
   input  logic [WIDTH-1:0]      i_data_in,
   input  logic [MEM_SIZE+1:0]   i_read_add,
   output logic [WIDTH-1:0]      o_data_out,
   output logic [MEM_SIZE-1:0]   o_number_out,
   output logic [1:0]            o_start_out,
   output logic                  o_overflow
);

   localparam int                  DEPTH   = 1 << MEM_SIZE;
   localparam logic [MEM_SIZE-1:0] MAX_CNT = {MEM_SIZE{1'b1}};

   logic [1:0]          r_wr_page;
   logic [MEM_SIZE-1:0] r_cnt [4];
   logic [3:0]          r_ovf;
   logic [WIDTH-1:0]    r_mem [4*DEPTH];

   logic [1:0]          w_tgt_page;
   logic [MEM_SIZE-1:0] w_tgt_cnt;
   logic                w_full;
   logic                w_wr_en;

   // A write coinciding with a boundary lands in the freshly cleared next page,
   // so its effective fill level is zero regardless of stale counter contents.
   always_comb begin
      w_tgt_page = i_start[0] ? r_wr_page + 2'd1 : r_wr_page;
      w_tgt_cnt  = i_start[0] ? '0 : r_cnt[r_wr_page];
      w_full     = (w_tgt_cnt == MAX_CNT);
      w_wr_en    = i_input_valid && !w_full;
   end

   // NOTE: all registered state uses non-blocking assignments so every flop
   // samples pre-edge values and ordering between always_ff blocks is irrelevant.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_wr_page    <= '0;
         r_ovf        <= '0;
         o_number_out <= '0;
         o_start_out  <= '0;
         for (int p = 0; p < 4; p++) r_cnt[p] <= '0;
      end else begin
         o_start_out <= i_start;
         if (i_start[0]) begin
            r_wr_page    <= w_tgt_page;
            o_number_out <= r_cnt[r_wr_page];
         end
         for (int p = 0; p < 4; p++) begin
            if (i_start[0] && w_tgt_page == 2'(p)) begin
               r_cnt[p] <= {{(MEM_SIZE-1){1'b0}}, w_wr_en};
               r_ovf[p] <= 1'b0;
            end else if (i_input_valid && w_tgt_page == 2'(p)) begin
               if (w_full) r_ovf[p] <= 1'b1;
               else        r_cnt[p] <= r_cnt[p] + 1'b1;
            end
         end
      end
   end

   // NOTE: the storage array has no reset so it maps onto block RAM; only the
   // counters decide which entries are meaningful.
   always_ff @(posedge i_clk) begin
      if (w_wr_en) r_mem[{w_tgt_page, w_tgt_cnt}] <= i_data_in;
   end

   // Read-first: same-edge write and read of one address returns the old word.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) o_data_out <= '0;
      else          o_data_out <= r_mem[i_read_add];
   end

   assign o_overflow = r_ovf[r_wr_page];

endmodule

// File: tb/tb_proc_input_memory.sv
// Directed bench for proc_input_memory: a vector table for the basic event flow
// plus hand sequences for overflow, same-cycle boundary writes, wrap and reset.
module tb_proc_input_memory;

   localparam int WIDTH    = 36;
   localparam int MEM_SIZE = 6;

   logic                i_clk;
   logic                i_reset;
   logic [1:0]          i_start;
   logic                i_input_valid;
   logic [WIDTH-1:0]    i_data_in;
   logic [MEM_SIZE+1:0] i_read_add;
   logic [WIDTH-1:0]    o_data_out;
   logic [MEM_SIZE-1:0] o_number_out;
   logic [1:0]          o_start_out;
   logic                o_overflow;

   int checks   = 0;
   int failures = 0;

   proc_input_memory #(.WIDTH(WIDTH), .MEM_SIZE(MEM_SIZE)) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_start       (i_start),
      .i_input_valid (i_input_valid),
      .i_data_in     (i_data_in),
      .i_read_add    (i_read_add),
      .o_data_out    (o_data_out),
      .o_number_out  (o_number_out),
      .o_start_out   (o_start_out),
      .o_overflow    (o_overflow)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   typedef struct {
      logic             v;
      logic [WIDTH-1:0] d;
      logic [1:0]       s;
      logic [7:0]       a;
      logic             chk_d;
      logic [WIDTH-1:0] e_d;
      logic [5:0]       e_n;
      logic [1:0]       e_so;
      logic             e_ovf;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
   task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic [1:0] s,
                       input logic [7:0] a);
      i_input_valid = v;
      i_data_in     = d;
      i_start       = s;
      i_read_add    = a;
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_input_valid = 1'b0;
      i_data_in     = '0;
      i_start       = 2'd0;
      i_read_add    = '0;
      i_reset       = 1'b0;
      @(posedge i_clk);
      @(posedge i_clk);
      #1;
      i_reset = 1'b1;
   endtask

   initial begin
      i_reset = 1'b0;
      //          v     d       s     a     chk   e_d     e_n   e_so  e_ovf
      tbl[0] = '{1'b1, 36'h1, 2'd0, 8'd0, 1'b0, 36'h0, 6'd0, 2'd0, 1'b0};
      tbl[1] = '{1'b1, 36'h2, 2'd0, 8'd0, 1'b1, 36'h1, 6'd0, 2'd0, 1'b0};
      tbl[2] = '{1'b1, 36'h3, 2'd0, 8'd1, 1'b1, 36'h2, 6'd0, 2'd0, 1'b0};
      tbl[3] = '{1'b1, 36'h4, 2'd0, 8'd2, 1'b1, 36'h3, 6'd0, 2'd0, 1'b0};
      tbl[4] = '{1'b1, 36'h5, 2'd0, 8'd3, 1'b1, 36'h4, 6'd0, 2'd0, 1'b0};
      tbl[5] = '{1'b0, 36'h0, 2'd1, 8'd4, 1'b1, 36'h5, 6'd5, 2'd1, 1'b0};
      tbl[6] = '{1'b0, 36'h0, 2'd0, 8'd0, 1'b1, 36'h1, 6'd5, 2'd0, 1'b0};
      tbl[7] = '{1'b0, 36'h0, 2'd0, 8'd1, 1'b1, 36'h2, 6'd5, 2'd0, 1'b0};
      tbl[8] = '{1'b0, 36'h0, 2'd2, 8'd2, 1'b1, 36'h3, 6'd5, 2'd2, 1'b0};
      tbl[9] = '{1'b0, 36'h0, 2'd0, 8'd3, 1'b1, 36'h4, 6'd5, 2'd0, 1'b0};

      do_reset();
      check("reset data_out",   64'(o_data_out),   64'h0);
      check("reset number_out", 64'(o_number_out), 64'h0);
      check("reset start_out",  64'(o_start_out),  64'h0);
      check("reset overflow",   64'(o_overflow),   64'h0);

      // Basic event: five writes, boundary, read-back; start[1] is pass-through only
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].a);
         if (tbl[i].chk_d) check($sformatf("tbl[%0d] data_out", i), 64'(o_data_out), 64'(tbl[i].e_d));
         check($sformatf("tbl[%0d] number_out", i), 64'(o_number_out), 64'(tbl[i].e_n));
         check($sformatf("tbl[%0d] start_out", i),  64'(o_start_out),  64'(tbl[i].e_so));
         check($sformatf("tbl[%0d] overflow", i),   64'(o_overflow),   64'(tbl[i].e_ovf));
      end

      // Write in the boundary cycle goes to the new page and counts as its first entry
      do_reset();
      for (int k = 0; k < 3; k++) step(1'b1, 36'h10 + 36'(k), 2'd0, 8'd0);
      step(1'b1, 36'hAA, 2'd1, 8'd0);
      check("same-cycle number_out", 64'(o_number_out), 64'd3);
      check("same-cycle start_out",  64'(o_start_out),  64'd1);
      step(1'b0, 36'h0, 2'd0, 8'd64);
      check("page1 entry0", 64'(o_data_out), 64'hAA);
      step(1'b0, 36'h0, 2'd0, 8'd2);
      check("page0 entry2", 64'(o_data_out), 64'h12);
      step(1'b0, 36'h0, 2'd1, 8'd0);
      check("new page count", 64'(o_number_out), 64'd1);

      // Read-first collision on page 0 entry 0 (holds 0x10 from above)
      do_reset();
      step(1'b1, 36'h333, 2'd0, 8'd0);
      check("collision old word", 64'(o_data_out), 64'h10);
      step(1'b0, 36'h0, 2'd0, 8'd0);
      check("collision new word", 64'(o_data_out), 64'h333);

      // Overflow: 70 writes into a 63-entry page
      do_reset();
      for (int i = 0; i < 70; i++) begin
         step(1'b1, 36'(i + 1), 2'd0, 8'd0);
         check($sformatf("overflow after write %0d", i + 1), 64'(o_overflow), 64'(i >= 63));
      end
      step(1'b0, 36'h0, 2'd1, 8'd0);
      check("saturated number_out",   64'(o_number_out), 64'd63);
      check("overflow cleared on new page", 64'(o_overflow), 64'd0);
      step(1'b0, 36'h0, 2'd0, 8'd62);
      check("entry62 holds word 63", 64'(o_data_out), 64'd63);
      step(1'b0, 36'h0, 2'd0, 8'd0);
      check("entry0 holds word 1", 64'(o_data_out), 64'd1);

      // Five events wrap the write page back to page 0
      do_reset();
      for (int e = 0; e < 5; e++) begin
         for (int k = 0; k < 2 * (e + 1); k++) step(1'b1, 36'((e << 8) | k), 2'd0, 8'd0);
         step(1'b0, 36'h0, 2'd1, 8'd0);
         check($sformatf("event %0d number_out", e), 64'(o_number_out), 64'(2 * (e + 1)));
      end
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 36'h0, 2'd0, 8'(k));
         check($sformatf("wrapped page0 entry%0d", k), 64'(o_data_out), 64'((4 << 8) | k));
      end
      for (int k = 0; k < 3; k++) step(1'b1, 36'h900 + 36'(k), 2'd0, 8'd0);
      step(1'b0, 36'h0, 2'd1, 8'd0);
      check("back-to-back first", 64'(o_number_out), 64'd3);
      step(1'b0, 36'h0, 2'd1, 8'd0);
      check("skipped page count", 64'(o_number_out), 64'd0);

      // Asynchronous reset mid-event with nonzero outputs
      do_reset();
      step(1'b1, 36'h55, 2'd0, 8'd0);
      step(1'b1, 36'h56, 2'd0, 8'd0);
      step(1'b0, 36'h0, 2'd1, 8'd0);
      for (int k = 0; k < 3; k++) step(1'b1, 36'h57 + 36'(k), 2'd0, 8'd0);
      step(1'b0, 36'h0, 2'd2, 8'd0);
      check("pre-reset number_out", 64'(o_number_out), 64'd2);
      check("pre-reset start_out",  64'(o_start_out),  64'd2);
      check("pre-reset data_out",   64'(o_data_out),   64'h55);
      #2 i_reset = 1'b0;
      #1;
      check("async data_out",   64'(o_data_out),   64'h0);
      check("async number_out", 64'(o_number_out), 64'h0);
      check("async start_out",  64'(o_start_out),  64'h0);
      check("async overflow",   64'(o_overflow),   64'h0);
      i_start = 2'd0;
      @(posedge i_clk);
      #1 i_reset = 1'b1;
      step(1'b1, 36'h77, 2'd0, 8'd0);
      step(1'b0, 36'h0, 2'd1, 8'd0);
      check("post-reset number_out", 64'(o_number_out), 64'd1);
      step(1'b0, 36'h0, 2'd0, 8'd0);
      check("post-reset page0 entry0", 64'(o_data_out), 64'h77);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
